// File: rtl/bsg_manycore_event_profiler.sv
// Per-tile event profiler: counts cycles and event strobes from unfreeze to finish, then dumps one record per counter.
// Latency: counters update on the sampling edge; the first record is valid the cycle after finish is sampled.
// Backpressure: valid/yumi dump; a record holds on data_o until yumi_i, one record per cycle under back-to-back yumi.
module bsg_manycore_event_profiler #(
  parameter int num_events_p    = 8,
  parameter int counter_width_p = 32,
  parameter int saturate_p      = 1,
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  localparam int idx_w_lp  = $clog2(num_events_p + 1),
  localparam int data_w_lp = x_cord_width_p + y_cord_width_p + idx_w_lp + counter_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic                      finish_i,
  input  logic [num_events_p-1:0]   events_i,
  input  logic [x_cord_width_p-1:0] x_id_i,
  input  logic [y_cord_width_p-1:0] y_id_i,
  output logic                      v_o,
  output logic [data_w_lp-1:0]      data_o,
  input  logic                      yumi_i,
  output logic [1:0]                state_o,
  output logic [num_events_p:0]     overflow_o
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam logic [1:0] DUMP  = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]                                    state_q, state_d;
  logic                                          freeze_r_q;
  logic [num_events_p:0][counter_width_p-1:0]    cnt_q, cnt_d;
  logic [num_events_p:0]                         ovf_q, ovf_d;
  logic [idx_w_lp-1:0]                           idx_q, idx_d;

  logic                  unfreeze;
  logic                  last_rec;
  logic [num_events_p:0] inc;

  // Slot 0 is the cycle counter, which increments on every unpaused cycle.
  assign inc      = {events_i, 1'b1};
  assign unfreeze = freeze_r_q & ~freeze_i;
  assign last_rec = (idx_q == idx_w_lp'(num_events_p));

  // Next-state, counter and dump-index logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        // A fresh run always starts from zeroed counters and overflow flags.
        if (unfreeze) begin
          state_d = COUNT;
          cnt_d   = '0;
          ovf_d   = '0;
        end
      end
      COUNT: begin
        // Re-freeze pauses counting without clearing; the finish cycle itself still counts.
        if (!freeze_i) begin
          for (int j = 0; j <= num_events_p; j++) begin
            if (inc[j]) begin
              if (&cnt_q[j]) begin
                ovf_d[j] = 1'b1;
                cnt_d[j] = (saturate_p != 0) ? cnt_q[j] : '0;
              end else begin
                cnt_d[j] = cnt_q[j] + counter_width_p'(1);
              end
            end
          end
        end
        if (finish_i) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (yumi_i) begin
          if (last_rec) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + idx_w_lp'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset aborts any run, including one mid-dump.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      freeze_r_q <= 1'b1;
      cnt_q      <= '0;
      ovf_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      freeze_r_q <= freeze_i;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
    end
  end

  assign v_o        = (state_q == DUMP);
  assign data_o     = v_o ? {x_id_i, y_id_i, idx_q, cnt_q[idx_q]} : '0;
  assign state_o    = state_q;
  assign overflow_o = ovf_q;

  // The consumer may only take a record that is actually offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_manycore_event_profiler.sv
// Testbench for bsg_manycore_event_profiler: one 32-bit saturating instance and two 4-bit instances (saturate / wrap).
// Latency: inputs change 1ns after a rising edge, outputs are sampled 1ns after the following rising edge.
// Backpressure: yumi_i is only driven while the reference model says a record is on offer.
module tb_bsg_manycore_event_profiler;

  localparam int N = 8;
  localparam int S_IDLE  = 0;
  localparam int S_COUNT = 1;
  localparam int S_DUMP  = 2;
  localparam int S_DONE  = 3;
  localparam logic [3:0] XID = 4'd3;
  localparam logic [3:0] YID = 4'd1;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         freeze_i;
  logic         finish_i;
  logic         yumi_i;
  logic [N-1:0] events_i;
  logic [3:0]   x_id_i;
  logic [3:0]   y_id_i;

  logic         v_m, v_s, v_w;
  logic [43:0]  d_m;
  logic [15:0]  d_s, d_w;
  logic [1:0]   st_m, st_s, st_w;
  logic [N:0]   ov_m, ov_s, ov_w;

  always #5 clk_i = ~clk_i;

  bsg_manycore_event_profiler #(.num_events_p(N), .counter_width_p(32), .saturate_p(1),
                                .x_cord_width_p(4), .y_cord_width_p(4)) u_main (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .freeze_i(freeze_i), .finish_i(finish_i),
    .events_i(events_i), .x_id_i(x_id_i), .y_id_i(y_id_i), .v_o(v_m), .data_o(d_m),
    .yumi_i(yumi_i), .state_o(st_m), .overflow_o(ov_m));

  bsg_manycore_event_profiler #(.num_events_p(N), .counter_width_p(4), .saturate_p(1),
                                .x_cord_width_p(4), .y_cord_width_p(4)) u_sat4 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .freeze_i(freeze_i), .finish_i(finish_i),
    .events_i(events_i), .x_id_i(x_id_i), .y_id_i(y_id_i), .v_o(v_s), .data_o(d_s),
    .yumi_i(yumi_i), .state_o(st_s), .overflow_o(ov_s));

  bsg_manycore_event_profiler #(.num_events_p(N), .counter_width_p(4), .saturate_p(0),
                                .x_cord_width_p(4), .y_cord_width_p(4)) u_wrap4 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .freeze_i(freeze_i), .finish_i(finish_i),
    .events_i(events_i), .x_id_i(x_id_i), .y_id_i(y_id_i), .v_o(v_w), .data_o(d_w),
    .yumi_i(yumi_i), .state_o(st_w), .overflow_o(ov_w));

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded event totals per counter; width effects applied only when read.
  int     mst;
  int     midx;
  bit     mfrz_r;
  longint mcnt  [N+1];
  longint rec_m [N+1];
  longint rec_s [N+1];
  longint rec_w [N+1];

  typedef struct {
    logic [N-1:0] ev;
    bit           frz;
    bit           fin;
    bit           yu;
    logic [1:0]   exp_st;
    bit           exp_v;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic longint expv(input longint n, input int w, input bit sat);
    longint lim;
    lim = longint'(1) << w;
    if (sat) return (n >= lim) ? lim - 1 : n;
    return n % lim;
  endfunction

  task automatic chk_dut(input string name, input logic [43:0] d, input logic [N:0] ov,
                         input logic [1:0] st, input logic v, input int w, input bit sat);
    logic [63:0] ed;
    logic [N:0]  eo;
    ed = '0;
    if (mst == S_DUMP)
      ed = (64'(XID) << (w + 8)) | (64'(YID) << (w + 4)) | (64'(midx) << w)
         | 64'(expv(mcnt[midx], w, sat));
    for (int j = 0; j <= N; j++) eo[j] = (mcnt[j] >= (longint'(1) << w));
    chk({name, " state"},    64'(st), 64'(mst));
    chk({name, " v_o"},      64'(v),  64'(mst == S_DUMP));
    chk({name, " overflow"}, 64'(ov), 64'(eo));
    chk({name, " data"},     64'(d),  ed);
  endtask

  task automatic chk_all();
    chk_dut("main",  d_m,      ov_m, st_m, v_m, 32, 1'b1);
    chk_dut("sat4",  44'(d_s), ov_s, st_s, v_s, 4,  1'b1);
    chk_dut("wrap4", 44'(d_w), ov_w, st_w, v_w, 4,  1'b0);
  endtask

  task automatic clear_recs();
    for (int j = 0; j <= N; j++) begin
      rec_m[j] = -1;
      rec_s[j] = -1;
      rec_w[j] = -1;
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic [N-1:0] ev, input bit frz, input bit fin, input bit yu);
    bit unf;
    bit yu_eff;
    yu_eff   = yu && (mst == S_DUMP);
    events_i = ev;
    freeze_i = frz;
    finish_i = fin;
    yumi_i   = yu_eff;
    unf      = mfrz_r && !frz;
    case (mst)
      S_IDLE, S_DONE: if (unf) begin
        mst = S_COUNT;
        for (int j = 0; j <= N; j++) mcnt[j] = 0;
      end
      S_COUNT: begin
        if (!frz) begin
          mcnt[0]++;
          for (int j = 0; j < N; j++) if (ev[j]) mcnt[j+1]++;
        end
        if (fin) begin
          mst  = S_DUMP;
          midx = 0;
        end
      end
      S_DUMP: if (yu_eff) begin
        if (midx == N) mst = S_DONE;
        else midx++;
      end
      default: ;
    endcase
    mfrz_r = frz;
    @(posedge clk_i);
    #1;
    chk_all();
    if (v_m) rec_m[d_m[35:32]] = longint'(d_m[31:0]);
    if (v_s) rec_s[d_s[7:4]]   = longint'(d_s[3:0]);
    if (v_w) rec_w[d_w[7:4]]   = longint'(d_w[3:0]);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    reset_n_i = 1'b0;
    freeze_i  = 1'b1;
    finish_i  = 1'b0;
    events_i  = '0;
    yumi_i    = 1'b0;
    mst       = S_IDLE;
    midx      = 0;
    mfrz_r    = 1'b1;
    for (int j = 0; j <= N; j++) mcnt[j] = 0;
    #1;
    chk_all();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int hold, input int yprob);
    for (int k = 0; k < hold; k++) cycle('0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 400 && mst == S_DUMP; k++)
      cycle(N'($urandom), 1'b1, 1'b1, ($urandom_range(0, 99) < yprob));
  endtask

  initial begin
    reset_n_i = 1'b0;
    x_id_i    = XID;
    y_id_i    = YID;
    async_reset();

    // Short directed table: finish ignored in IDLE, pause, simultaneous unfreeze+finish.
    tbl[0] = '{8'hff, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[3] = '{8'h05, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[6] = '{8'hff, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[8] = '{8'h00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    clear_recs();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].ev, tbl[i].frz, tbl[i].fin, tbl[i].yu);
      chk($sformatf("tbl%0d state", i), 64'(st_m), 64'(tbl[i].exp_st));
      chk($sformatf("tbl%0d v_o", i),   64'(v_m),  64'(tbl[i].exp_v));
    end
    drain(0, 100);
    chk("tbl cycles", rec_m[0], 2);
    chk("tbl ev0",    rec_m[1], 2);
    chk("tbl ev1",    rec_m[2], 1);

    // Basic run followed by backpressure on the dump.
    clear_recs();
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 100; i++)
      cycle({5'b0, (i % 2 == 0), 1'b0, 1'b1}, 1'b0, (i == 100), 1'b0);
    begin
      logic [43:0] held;
      held = d_m;
      for (int k = 0; k < 5; k++) begin
        cycle('0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("bp hold%0d", k), 64'(d_m), 64'(held));
      end
    end
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("bp rec idx%0d", k), 64'(d_m[35:32]), 64'(k));
      cycle('0, 1'b1, 1'b0, 1'b1);
    end
    chk("bp done state", 64'(st_m), 64'(S_DONE));
    chk("basic idx0", rec_m[0], 101);
    chk("basic idx1", rec_m[1], 101);
    chk("basic idx3", rec_m[3], 51);
    for (int j = 2; j <= N; j++)
      if (j != 3) chk($sformatf("basic idx%0d", j), rec_m[j], 0);
    cycle(8'hff, 1'b1, 1'b1, 1'b0);
    chk("done ignores finish", 64'(st_m), 64'(S_DONE));

    // Pause: re-freeze holds, re-unfreeze resumes without clearing.
    clear_recs();
    cycle('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(8'h02, 1'b0, 1'b0, 1'b0);
    cycle(8'h02, 1'b0, 1'b1, 1'b0);
    drain(0, 100);
    chk("pause cycles", rec_m[0], 21);
    chk("pause idx2",   rec_m[2], 21);
    chk("pause idx1",   rec_m[1], 0);

    // Saturation vs wrap on the 4-bit instances.
    clear_recs();
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(8'h01, 1'b0, 1'b0, 1'b0);
    cycle(8'h01, 1'b0, 1'b1, 1'b0);
    chk("sat4 ovf1",  64'(ov_s[1]), 1);
    chk("wrap4 ovf1", 64'(ov_w[1]), 1);
    drain(2, 100);
    chk("sat4 idx1",  rec_s[1], 15);
    chk("wrap4 idx1", rec_w[1], 5);
    chk("main idx1",  rec_m[1], 21);

    // Second run from DONE clears overflow; simultaneous finish+unfreeze in COUNT dumps.
    clear_recs();
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("rerun state",      64'(st_m), 64'(S_COUNT));
    chk("rerun sat4 ovf",   64'(ov_s), 0);
    chk("rerun wrap4 ovf",  64'(ov_w), 0);
    cycle(8'h10, 1'b1, 1'b0, 1'b0);
    cycle(8'h10, 1'b0, 1'b1, 1'b0);
    chk("simul fin+unfrz", 64'(st_m), 64'(S_DUMP));
    drain(0, 100);
    chk("rerun cycles", rec_m[0], 1);
    chk("rerun idx5",   rec_m[5], 1);
    chk("rerun sat4 idx1", rec_s[1], 0);

    // Reset in the middle of a dump, after three records.
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(N'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(8'hff, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle('0, 1'b1, 1'b0, 1'b1);
    async_reset();
    for (int k = 0; k < 4; k++) cycle(N'($urandom), 1'b1, 1'b1, 1'b0);
    chk("post-reset v_o", 64'(v_m), 0);

    // Randomised runs checked cycle by cycle against the model.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(20, 150);
      cycle('0, 1'b1, 1'b0, 1'b0);
      cycle(N'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < len; i++)
        cycle(N'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
      cycle(N'($urandom), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      drain($urandom_range(0, 3), 50);
      cycle(N'($urandom), 1'b1, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
